// File: rtl/mini68k_pkg.sv
// Shared SR bit positions, exception vector numbers and sequencer state encoding.
// Constants and one pure helper; no latency or backpressure of its own.
package mini68k_pkg;

  localparam int SR_S        = 13;
  localparam int SR_T        = 15;
  localparam int SR_IMASK_HI = 10;
  localparam int SR_IMASK_LO = 8;

  localparam logic [7:0] VEC_ILLEGAL   = 8'd4;
  localparam logic [7:0] VEC_PRIV      = 8'd8;
  localparam logic [7:0] VEC_TRACE     = 8'd9;
  localparam logic [7:0] VEC_AUTO_BASE = 8'd24;
  localparam logic [7:0] VEC_TRAP_BASE = 8'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_SETSR,
    ST_PUSHPC,
    ST_PUSHSR,
    ST_VEC,
    ST_POPSR,
    ST_POPPC
  } exc_state_e;

  // SR value on exception entry: supervisor on, trace off, interrupts raise the mask.
  function automatic logic [15:0] entry_sr(input logic [15:0] sr,
                                           input logic        is_int,
                                           input logic [2:0]  lvl);
    logic [15:0] r;
    r       = sr;
    r[SR_S] = 1'b1;
    r[SR_T] = 1'b0;
    if (is_int) r[SR_IMASK_HI:SR_IMASK_LO] = lvl;
    return r;
  endfunction

endpackage

// File: rtl/mini68k_exc_seq_prio.sv
// Combinational boundary arbitration: illegal > trap > rte > trace > interrupt (trace only with MINI68K_EXC_TRACE_EN).
// Zero latency; no backpressure, the sequencer only consults take_o while idle.
module mini68k_exc_prio
  import mini68k_pkg::*;
(
  input  logic       insn_boundary_i,
  input  logic       illegal_req_i,
  input  logic       trap_req_i,
  input  logic [3:0] trap_num_i,
  input  logic       rte_req_i,
  input  logic [2:0] ipl_i,
  input  logic [2:0] imask_i,
  input  logic       sr_s_i,
  input  logic       sr_t_i,
  output logic       take_o,
  output logic [7:0] vec_o,
  output logic       is_int_o,
  output logic       is_rte_o,
  output logic [2:0] lvl_o
);

  logic int_pend;

  // Level 7 is non-maskable; lower levels must exceed the current mask.
  assign int_pend = (ipl_i == 3'd7) || (ipl_i > imask_i);

  always_comb begin
    take_o   = 1'b0;
    vec_o    = 8'd0;
    is_int_o = 1'b0;
    is_rte_o = 1'b0;
    lvl_o    = ipl_i;
    if (insn_boundary_i) begin
      if (illegal_req_i) begin
        take_o = 1'b1;
        vec_o  = VEC_ILLEGAL;
      end else if (trap_req_i) begin
        take_o = 1'b1;
        vec_o  = VEC_TRAP_BASE + {4'd0, trap_num_i};
      end else if (rte_req_i) begin
        take_o = 1'b1;
        if (sr_s_i) is_rte_o = 1'b1;
        else        vec_o    = VEC_PRIV;
`ifdef MINI68K_EXC_TRACE_EN
      end else if (sr_t_i) begin
        take_o = 1'b1;
        vec_o  = VEC_TRACE;
`endif
      end else if (int_pend) begin
        take_o   = 1'b1;
        vec_o    = VEC_AUTO_BASE + {5'd0, ipl_i};
        is_int_o = 1'b1;
      end
    end
  end

`ifndef MINI68K_EXC_TRACE_EN
  logic unused_sr_t;
  assign unused_sr_t = sr_t_i;
`endif

endmodule

// File: rtl/mini68k_exc_seq.sv
// Exception/interrupt entry and RTE sequencer, sole SR writer; trace vector 9 only with MINI68K_EXC_TRACE_EN.
// Latency: SR write 2 cycles after accept, then one handshake per stack/vector access; mem_* held until mem_ack, requests ignored while busy.
module mini68k_exc_seq
  import mini68k_pkg::*;
#(
  parameter int                ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] VBR_BASE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              insn_boundary,
  input  logic              illegal_req,
  input  logic              trap_req,
  input  logic [3:0]        trap_num,
  input  logic              rte_req,
  input  logic [2:0]        ipl,
  input  logic [31:0]       cur_pc,
  input  logic [15:0]       sr_out,
  output logic [15:0]       sr_in,
  output logic              sr_we,
  input  logic [ADDR_W-1:0] ssp,
  output logic [ADDR_W-1:0] ssp_nxt,
  output logic              ssp_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              pc_load,
  output logic [31:0]       pc_new,
  output logic              busy,
  output logic              int_ack,
  output logic [2:0]        int_ack_lvl
);

  exc_state_e        state_q;
  logic [15:0]       sr_save_q;
  logic [31:0]       pc_save_q;
  logic [7:0]        vec_q;
  logic              is_int_q;
  logic [2:0]        lvl_q;
  logic [ADDR_W-1:0] sp_q;

  logic [15:0]       sr_in_q;
  logic              sr_we_q, ssp_we_q, mem_req_q, mem_we_q, pc_load_q, busy_q, int_ack_q;
  logic [ADDR_W-1:0] ssp_nxt_q, mem_addr_q;
  logic [31:0]       mem_wdata_q, pc_new_q;
  logic [2:0]        int_ack_lvl_q;

  logic              take_w, is_int_w, is_rte_w;
  logic [7:0]        vec_w;
  logic [2:0]        lvl_w;

  logic [ADDR_W-1:0] sp_dn_d, sp_up_d, vec_addr_d;

  mini68k_exc_prio u_prio (
    .insn_boundary_i (insn_boundary),
    .illegal_req_i   (illegal_req),
    .trap_req_i      (trap_req),
    .trap_num_i      (trap_num),
    .rte_req_i       (rte_req),
    .ipl_i           (ipl),
    .imask_i         (sr_out[SR_IMASK_HI:SR_IMASK_LO]),
    .sr_s_i          (sr_out[SR_S]),
    .sr_t_i          (sr_out[SR_T]),
    .take_o          (take_w),
    .vec_o           (vec_w),
    .is_int_o        (is_int_w),
    .is_rte_o        (is_rte_w),
    .lvl_o           (lvl_w)
  );

  // The stack pointer is tracked locally so back-to-back pushes never see a stale ssp input.
  assign sp_dn_d    = sp_q - ADDR_W'(4);
  assign sp_up_d    = sp_q + ADDR_W'(4);
  assign vec_addr_d = VBR_BASE + ADDR_W'({vec_q, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sr_save_q     <= 16'h2700;
      pc_save_q     <= 32'd0;
      vec_q         <= 8'd0;
      is_int_q      <= 1'b0;
      lvl_q         <= 3'd0;
      sp_q          <= '0;
      sr_in_q       <= 16'd0;
      sr_we_q       <= 1'b0;
      ssp_nxt_q     <= '0;
      ssp_we_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 32'd0;
      pc_load_q     <= 1'b0;
      pc_new_q      <= 32'd0;
      busy_q        <= 1'b0;
      int_ack_q     <= 1'b0;
      int_ack_lvl_q <= 3'd0;
    end else begin
      sr_we_q   <= 1'b0;
      ssp_we_q  <= 1'b0;
      pc_load_q <= 1'b0;
      int_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (take_w) begin
          busy_q    <= 1'b1;
          sr_save_q <= sr_out;
          pc_save_q <= cur_pc;
          vec_q     <= vec_w;
          is_int_q  <= is_int_w;
          lvl_q     <= lvl_w;
          sp_q      <= ssp;
          state_q   <= is_rte_w ? ST_POPSR : ST_SAVE;
        end
        ST_SAVE: begin
          sr_we_q   <= 1'b1;
          sr_in_q   <= entry_sr(sr_save_q, is_int_q, lvl_q);
          int_ack_q <= is_int_q;
          if (is_int_q) int_ack_lvl_q <= lvl_q;
          state_q   <= ST_SETSR;
        end
        ST_SETSR: state_q <= ST_PUSHPC;
        // Memory states: first cycle launches the request, then hold until ack.
        ST_PUSHPC, ST_PUSHSR: begin
          if (!mem_req_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= sp_dn_d;
            mem_wdata_q <= (state_q == ST_PUSHPC) ? pc_save_q : {16'h0000, sr_save_q};
          end else if (mem_ack) begin
            mem_req_q <= 1'b0;
            ssp_we_q  <= 1'b1;
            ssp_nxt_q <= sp_dn_d;
            sp_q      <= sp_dn_d;
            state_q   <= (state_q == ST_PUSHPC) ? ST_PUSHSR : ST_VEC;
          end
        end
        ST_VEC: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= vec_addr_d;
          end else if (mem_ack) begin
            mem_req_q <= 1'b0;
            pc_load_q <= 1'b1;
            pc_new_q  <= mem_rdata;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_POPSR, ST_POPPC: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= sp_q;
          end else if (mem_ack) begin
            mem_req_q <= 1'b0;
            ssp_we_q  <= 1'b1;
            ssp_nxt_q <= sp_up_d;
            sp_q      <= sp_up_d;
            if (state_q == ST_POPSR) begin
              sr_save_q <= mem_rdata[15:0];
              state_q   <= ST_POPPC;
            end else begin
              sr_we_q   <= 1'b1;
              sr_in_q   <= sr_save_q;
              pc_load_q <= 1'b1;
              pc_new_q  <= mem_rdata;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sr_in       = sr_in_q;
  assign sr_we       = sr_we_q;
  assign ssp_nxt     = ssp_nxt_q;
  assign ssp_we      = ssp_we_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign pc_load     = pc_load_q;
  assign pc_new      = pc_new_q;
  assign busy        = busy_q;
  assign int_ack     = int_ack_q;
  assign int_ack_lvl = int_ack_lvl_q;

endmodule
